hist_cdf_gen: RTL and testbench
===============================

Name: hist_cdf_gen

Overview:
- Upstream neighbour of the histogram-equalisation mapping stage.
- Counts gray-level occurrences over one frame of the incoming 8-bit pixel stream, one counter per level.
- After the frame ends, sweeps levels 0..255 and emits the running cumulative count (the CDF) on the pixel_level / pixel_level_acc_num / pixel_level_valid bus that loads the mapping stage's lookup RAM.
- Clears its own counters during the sweep, ready for the next frame.

Parameters:
C_CNT_WIDTH, 20, width of each per-level counter, the accumulator and pixel_level_acc_num (2^20 covers frames up to 1M pixels)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
per_img_vsync  input  1  frame-valid, high for the whole active frame
per_img_href  input  1  pixel-valid qualifier, meaningful only while per_img_vsync=1
per_img_gray  input  8  pixel gray value
pixel_level  output  8  gray level being reported
pixel_level_acc_num  output  C_CNT_WIDTH  cumulative count of pixels with gray <= pixel_level
pixel_level_valid  output  1  one-cycle qualifier per reported level
hist_busy  output  1  high while initialising or sweeping; frames starting then are dropped

Behaviour:
- Storage: internal 256 x C_CNT_WIDTH simple-dual-port RAM with synchronous read. Old data is returned on a same-address read/write collision. Contents are not reset.
- State machine: INIT -> IDLE -> COUNT -> DRAIN -> SWEEP -> IDLE.
- INIT: entered on reset. Writes 0 to addresses 0..255, one per cycle (256 cycles), with hist_busy=1, then goes to IDLE.
- IDLE: hist_busy=0.
  - A rising edge of per_img_vsync (registered copy low, input high) -> COUNT.
  - A frame already in progress when IDLE is entered is ignored until its vsync falls and rises again.
- COUNT: each cycle with per_img_vsync=1 and per_img_href=1 increments mem[per_img_gray] through a 2-stage read-modify-write pipeline.
  - S1: register gray/valid, issue read.
  - S2: write rdata+1.
  - Hazard rule: if the S2 address equals the S1 address of the previous cycle's S2 write, S2 uses the forwarded write data instead of rdata. Back-to-back identical grays must count exactly.
- Counter overflow: wraps modulo 2^C_CNT_WIDTH (see optional feature).
- A falling edge of per_img_vsync -> DRAIN (2 cycles, lets the RMW pipeline retire) -> SWEEP.
- SWEEP: hist_busy=1.
  - Reads addresses 0..255 consecutively and writes 0 to each address one cycle after its read.
  - Accumulator starts at 0 and adds each read value.
  - Outputs are registered: pixel_level=i, pixel_level_acc_num=sum of mem[0..i], pixel_level_valid=1 for exactly 256 consecutive cycles in ascending order.
  - The first valid occurs exactly 4 clk edges after the edge at which per_img_vsync is first sampled low.
  - The level-255 value equals the total counted pixels (mod 2^C_CNT_WIDTH). The downstream stage keys its start flag on this entry.
  - Returns to IDLE after the last write.
- A vsync rising edge while hist_busy=1 is ignored: that whole frame is neither counted nor swept.
- Outputs outside SWEEP: pixel_level_valid=0; pixel_level and pixel_level_acc_num hold their last value.
- Reset values: pixel_level=0, pixel_level_acc_num=0, pixel_level_valid=0, hist_busy=1 (INIT).
- Reset mid-COUNT or mid-SWEEP: outputs go to reset values immediately, the FSM re-enters INIT, and RAM is re-cleared. No partial sweep resumes.
- Zero-pixel frame (vsync pulse with href never high): the sweep still runs, with all 256 outputs 0.

Optional Feature:
- Macro HIST_CDF_SAT_EN.
- Defined:
  - Per-level counters saturate at 2^C_CNT_WIDTH-1 (the increment is suppressed at max, including on the forwarded path).
  - The accumulator saturates at 2^C_CNT_WIDTH-1 instead of wrapping.
- Undefined: counters and accumulator wrap modulo 2^C_CNT_WIDTH, with no saturation logic.

Test Plan:
- Release reset -> hist_busy=1 for 256 cycles then 0; pixel_level_valid stays 0; a subsequent empty frame sweeps with all acc_num=0.
- 4x4 frame with every pixel gray 10 -> 256 valids. Levels 0..9 give acc_num=0; levels 10..255 give acc_num=16. First valid is exactly 4 cycles after vsync is sampled low.
- One line with grays 5,5,5,7,7,5,200,200 back-to-back (href continuously high) -> acc_num: 0 at level 4, 4 at level 5, 4 at level 6, 6 at level 7, 6 at level 199, 8 at levels 200 and 255.
- Frame A of 16 pixels of gray 0, then frame B of 4 pixels of gray 3 -> frame B reports level 0=0, level 3=4, level 255=4, proving the clear-during-sweep.
- Frame B's vsync rises 100 cycles into frame A's sweep -> A's 256 outputs complete unchanged. B produces no sweep and no counting, and the next frame is counted from zero.
- C_CNT_WIDTH=4, 20 pixels of gray 0 -> level 255 reports 15 with HIST_CDF_SAT_EN defined and 4 without.

Source files
------------

// File: rtl/hist_cdf_if.sv
// Pixel-stream input and CDF output bus of the histogram/CDF stage.
// DUT side uses the slave modport. The pixel source side uses the master modport.
interface hist_cdf_if #(
  parameter int C_CNT_WIDTH = 20
);
  // Handshake semantics: there is no ready signal anywhere on this bus.
  // - per_img_href qualifies per_img_gray only while per_img_vsync=1.
  // - pixel_level_valid qualifies pixel_level/pixel_level_acc_num for exactly one cycle per level.
  // - The consumer must accept every valid beat in the cycle it appears.
  logic                   per_img_vsync;
  logic                   per_img_href;
  logic [7:0]             per_img_gray;
  logic [7:0]             pixel_level;
  logic [C_CNT_WIDTH-1:0] pixel_level_acc_num;
  logic                   pixel_level_valid;
  logic                   hist_busy;

  modport master (
    output per_img_vsync, per_img_href, per_img_gray,
    input  pixel_level, pixel_level_acc_num, pixel_level_valid, hist_busy
  );

  modport slave (
    input  per_img_vsync, per_img_href, per_img_gray,
    output pixel_level, pixel_level_acc_num, pixel_level_valid, hist_busy
  );
endinterface

// File: rtl/hist_cdf_gen.sv
// Per-frame gray-level histogram, swept out afterwards as a cumulative count (CDF).
// Define HIST_CDF_SAT_EN to make the counters and the accumulator saturate instead of wrap.
module hist_cdf_gen #(
  parameter int C_CNT_WIDTH = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  hist_cdf_if.slave    bus,
  output logic [2:0]   dbg_state_o
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_COUNT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SWEEP = 3'd4
  } state_t;

  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};
`ifdef HIST_CDF_SAT_EN
  localparam logic [C_CNT_WIDTH-1:0] CNT_MAX = '1;
`endif

  state_t                 state_q;
  logic [7:0]             init_cnt_q;
  logic                   vsync_q;
  logic                   drain_cnt_q;
  logic [8:0]             sweep_cnt_q;
  logic                   rd_vld_q;
  logic [7:0]             rd_lvl_q;
  logic                   s1_vld_q;
  logic [7:0]             s1_gray_q;
  logic                   wr_vld_q;
  logic [7:0]             wr_addr_q;
  logic [C_CNT_WIDTH-1:0] wr_data_q;
  logic [7:0]             level_q;
  logic [C_CNT_WIDTH-1:0] acc_q;
  logic                   valid_q;
  logic                   busy_q;

  logic [C_CNT_WIDTH-1:0] mem [256];
  logic [C_CNT_WIDTH-1:0] rdata_q;

  logic                   vs_rise;
  logic                   vs_fall;
  logic                   pix_take;
  logic                   sweep_rd;
  logic                   rd_en;
  logic [7:0]             rd_addr;
  logic [C_CNT_WIDTH-1:0] rmw_src;
  logic [C_CNT_WIDTH-1:0] rmw_inc;
  logic [C_CNT_WIDTH-1:0] acc_base;
  logic [C_CNT_WIDTH-1:0] acc_next;
  logic                   we;
  logic [7:0]             waddr;
  logic [C_CNT_WIDTH-1:0] wdata;
`ifdef HIST_CDF_SAT_EN
  logic [C_CNT_WIDTH:0]   acc_sum;
`endif

  assign vs_rise  = bus.per_img_vsync & ~vsync_q;
  assign vs_fall  = ~bus.per_img_vsync & vsync_q;
  // A pixel arriving on the very edge that opens the frame is counted too
  assign pix_take = bus.per_img_vsync & bus.per_img_href &
                    ((state_q == ST_COUNT) | ((state_q == ST_IDLE) & vs_rise));
  assign sweep_rd = (state_q == ST_SWEEP) & ~sweep_cnt_q[8];
  assign rd_en    = pix_take | sweep_rd;
  assign rd_addr  = sweep_rd ? sweep_cnt_q[7:0] : bus.per_img_gray;

  // The RAM returns old data when the read and the write hit the same address.
  // Take the value that was just written instead.
  always_comb begin
    rmw_src = rdata_q;
    if (wr_vld_q && (wr_addr_q == s1_gray_q)) begin
      rmw_src = wr_data_q;
    end
`ifdef HIST_CDF_SAT_EN
    rmw_inc = (rmw_src == CNT_MAX) ? rmw_src : (rmw_src + CNT_ONE);
`else
    rmw_inc = rmw_src + CNT_ONE;
`endif
  end

  always_comb begin
    acc_base = (rd_lvl_q == 8'd0) ? '0 : acc_q;
`ifdef HIST_CDF_SAT_EN
    acc_sum  = {1'b0, acc_base} + {1'b0, rdata_q};
    acc_next = acc_sum[C_CNT_WIDTH] ? CNT_MAX : acc_sum[C_CNT_WIDTH-1:0];
`else
    acc_next = acc_base + rdata_q;
`endif
  end

  // The init clear, the counting increments and the sweep clear never overlap in time
  always_comb begin
    we    = 1'b0;
    waddr = 8'd0;
    wdata = '0;
    if (state_q == ST_INIT) begin
      we    = 1'b1;
      waddr = init_cnt_q;
    end else if (s1_vld_q) begin
      we    = 1'b1;
      waddr = s1_gray_q;
      wdata = rmw_inc;
    end else if (rd_vld_q) begin
      we    = 1'b1;
      waddr = rd_lvl_q;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (rd_en) begin
      rdata_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= 8'd0;
      vsync_q     <= 1'b0;
      drain_cnt_q <= 1'b0;
      sweep_cnt_q <= 9'd0;
      rd_vld_q    <= 1'b0;
      rd_lvl_q    <= 8'd0;
      s1_vld_q    <= 1'b0;
      s1_gray_q   <= 8'd0;
      wr_vld_q    <= 1'b0;
      wr_addr_q   <= 8'd0;
      wr_data_q   <= '0;
      level_q     <= 8'd0;
      acc_q       <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      vsync_q   <= bus.per_img_vsync;
      s1_vld_q  <= pix_take;
      s1_gray_q <= bus.per_img_gray;
      wr_vld_q  <= s1_vld_q;
      wr_addr_q <= s1_gray_q;
      wr_data_q <= rmw_inc;
      rd_vld_q  <= sweep_rd;
      if (sweep_rd) begin
        rd_lvl_q <= sweep_cnt_q[7:0];
      end
      valid_q <= rd_vld_q;
      if (rd_vld_q) begin
        level_q <= rd_lvl_q;
        acc_q   <= acc_next;
      end

      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 8'd1;
          if (init_cnt_q == 8'hFF) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (vs_rise) begin
            state_q <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (vs_fall) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          drain_cnt_q <= 1'b1;
          if (drain_cnt_q) begin
            state_q     <= ST_SWEEP;
            busy_q      <= 1'b1;
            sweep_cnt_q <= 9'd0;
          end
        end
        ST_SWEEP: begin
          if (sweep_rd) begin
            sweep_cnt_q <= sweep_cnt_q + 9'd1;
          end
          // Leave once level 255 has been reported and cleared
          if (rd_vld_q && (rd_lvl_q == 8'hFF)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_INIT;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pixel_level         = level_q;
  assign bus.pixel_level_acc_num = acc_q;
  assign bus.pixel_level_valid   = valid_q;
  assign bus.hist_busy           = busy_q;
  assign dbg_state_o             = state_q;

endmodule

// File: tb/tb_hist_cdf_gen.sv
// Bench for hist_cdf_gen: a 20-bit and a 4-bit instance share one random pixel stream.
// Both are compared every cycle against a frame-level histogram/CDF model.
module tb_hist_cdf_gen;

  localparam int M_INIT  = 0;
  localparam int M_IDLE  = 1;
  localparam int M_COUNT = 2;
  localparam int M_SWEEP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       vs = 1'b0;
  logic       href = 1'b0;
  logic [7:0] gray = 8'd0;
  logic [2:0] dbg20, dbg4;

  hist_cdf_if #(.C_CNT_WIDTH(20)) bus20();
  hist_cdf_if #(.C_CNT_WIDTH(4))  bus4();

  assign bus20.per_img_vsync = vs;
  assign bus20.per_img_href  = href;
  assign bus20.per_img_gray  = gray;
  assign bus4.per_img_vsync  = vs;
  assign bus4.per_img_href   = href;
  assign bus4.per_img_gray   = gray;

  hist_cdf_gen #(.C_CNT_WIDTH(20)) dut20 (.clk(clk), .rst_n(rst_n), .bus(bus20), .dbg_state_o(dbg20));
  hist_cdf_gen #(.C_CNT_WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4),  .dbg_state_o(dbg4));

  int nchecks = 0;
  int nerr = 0;

  // ---------------- behavioural model ----------------
  int          m_st;
  int          m_init_left;
  bit          m_vs_prev;
  int          m_k;
  int          m_cyc = 0;
  int          m_fall_cyc = 0;
  int unsigned m_hist[256];
  logic [19:0] e20[256];
  logic [3:0]  e4[256];
  bit          e_valid;
  logic [7:0]  e_level;
  logic [19:0] e_acc20;
  logic [3:0]  e_acc4;
  int          e_busy;    // 1, 0, or -1 for don't care

  function automatic void build_cdf();
    longint s20 = 0;
    longint s4 = 0;
    for (int l = 0; l < 256; l++) begin
`ifdef HIST_CDF_SAT_EN
      s20 += (m_hist[l] > 1048575) ? 1048575 : m_hist[l];
      if (s20 > 1048575) s20 = 1048575;
      s4 += (m_hist[l] > 15) ? 15 : m_hist[l];
      if (s4 > 15) s4 = 15;
`else
      s20 = (s20 + m_hist[l]) % 1048576;
      s4  = (s4 + m_hist[l]) % 16;
`endif
      e20[l] = s20[19:0];
      e4[l]  = s4[3:0];
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = M_INIT; m_init_left = 256; m_vs_prev = 1'b0;
      e_valid = 1'b0; e_level = 8'd0; e_acc20 = 20'd0; e_acc4 = 4'd0; e_busy = 1;
    end else begin
      m_cyc++;
      e_valid = 1'b0;
      case (m_st)
        M_INIT: begin
          m_init_left--;
          if (m_init_left == 0) begin m_st = M_IDLE; e_busy = 0; end
        end
        M_IDLE: begin
          if (vs && !m_vs_prev) begin
            for (int l = 0; l < 256; l++) m_hist[l] = 0;
            m_st = M_COUNT;
            if (href) m_hist[gray]++;
          end
        end
        M_COUNT: begin
          if (!vs) begin
            build_cdf();
            m_k = 0; m_fall_cyc = m_cyc; m_st = M_SWEEP; e_busy = -1;
          end else if (href) begin
            m_hist[gray]++;
          end
        end
        default: begin
          m_k++;
          if (m_k >= 4) begin
            e_valid = 1'b1; e_level = 8'(m_k - 4);
            e_acc20 = e20[m_k - 4]; e_acc4 = e4[m_k - 4]; e_busy = 1;
          end
          if (m_k == 259) begin m_st = M_IDLE; e_busy = 0; end
        end
      endcase
      m_vs_prev = vs;
    end
  end

  // ---------------- per-cycle compare + capture ----------------
  logic [19:0] cap20[256];
  logic [3:0]  cap4[256];
  int          nvalid = 0;
  int          first_cyc = 0;
  bit          prev_valid = 1'b0;

  always @(negedge clk) begin
    nchecks++;
    if (bus20.pixel_level_valid !== e_valid || bus20.pixel_level !== e_level ||
        bus20.pixel_level_acc_num !== e_acc20 ||
        (e_busy >= 0 && bus20.hist_busy !== (e_busy == 1))) begin
      nerr++;
      $display("FAIL out20 cyc %0d: got v=%b l=%0d a=%0d b=%b expected v=%b l=%0d a=%0d b=%0d",
               m_cyc, bus20.pixel_level_valid, bus20.pixel_level, bus20.pixel_level_acc_num,
               bus20.hist_busy, e_valid, e_level, e_acc20, e_busy);
    end
    nchecks++;
    if (bus4.pixel_level_valid !== e_valid || bus4.pixel_level !== e_level ||
        bus4.pixel_level_acc_num !== e_acc4 ||
        (e_busy >= 0 && bus4.hist_busy !== (e_busy == 1))) begin
      nerr++;
      $display("FAIL out4 cyc %0d: got v=%b l=%0d a=%0d b=%b expected v=%b l=%0d a=%0d b=%0d",
               m_cyc, bus4.pixel_level_valid, bus4.pixel_level, bus4.pixel_level_acc_num,
               bus4.hist_busy, e_valid, e_level, e_acc4, e_busy);
    end
    if (bus20.pixel_level_valid === 1'b1) begin
      cap20[bus20.pixel_level] = bus20.pixel_level_acc_num;
      cap4[bus4.pixel_level]   = bus4.pixel_level_acc_num;
      nvalid++;
      if (!prev_valid) first_cyc = m_cyc;
    end
    prev_valid = (bus20.pixel_level_valid === 1'b1);
  end

  // ---------------- driver tasks ----------------
  logic [7:0] pix_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_caps();
    for (int l = 0; l < 256; l++) begin cap20[l] = 'x; cap4[l] = 'x; end
    nvalid = 0;
  endtask

  task automatic run_frame(input int gap_max, input int line_len);
    vs = 1'b1; href = 1'b0; tick(2);
    foreach (pix_q[i]) begin
      if (line_len > 0 && i > 0 && (i % line_len) == 0) begin
        href = 1'b0; tick(2);
      end
      if (gap_max > 0 && $urandom_range(0, 3) == 0) begin
        href = 1'b0; gray = 8'($urandom); tick($urandom_range(1, gap_max));
      end
      href = 1'b1; gray = pix_q[i]; tick(1);
    end
    href = 1'b0; gray = 8'($urandom); tick(2);
    vs = 1'b0; tick(1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (m_st != M_IDLE && n < 2000) begin tick(1); n++; end
    check({name, "_idle_timeout"}, (n < 2000), 1);
    tick(2);
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (bus20.hist_busy === 1'b1 && n < 400) begin tick(1); n++; end
    check(name, n, 256);
  endtask

  task automatic fill(input int val, input int count);
    pix_q.delete();
    for (int i = 0; i < count; i++) pix_q.push_back(8'(val));
  endtask

  task automatic fill_random(input int count);
    pix_q.delete();
    for (int i = 0; i < count; i++)
      pix_q.push_back(($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    tick(1);
    check("rst_valid", bus20.pixel_level_valid, 0);
    check("rst_level", bus20.pixel_level, 0);
    check("rst_acc", bus20.pixel_level_acc_num, 0);
    check("rst_busy", bus20.hist_busy, 1);
    tick(2);
    rst_n = 1'b1;
    wait_init("init_busy_cycles");

    // empty frame after init
    clear_caps(); pix_q.delete(); run_frame(0, 0); wait_idle("empty");
    check("empty_nvalid", nvalid, 256);
    check("empty_l255", cap20[255], 0);

    // 4x4 frame of gray 10
    clear_caps(); fill(10, 16); run_frame(0, 4); wait_idle("g10");
    check("g10_latency", first_cyc - m_fall_cyc, 4);
    check("g10_model_l10", e20[10], 16);
    check("g10_l9", cap20[9], 0);
    check("g10_l10", cap20[10], 16);
    check("g10_l255", cap20[255], 16);
    check("g10_nvalid", nvalid, 256);

    // back-to-back hazard line
    clear_caps();
    pix_q = '{8'd5, 8'd5, 8'd5, 8'd7, 8'd7, 8'd5, 8'd200, 8'd200};
    run_frame(0, 0); wait_idle("b2b");
    check("b2b_model_l7", e20[7], 6);
    check("b2b_l4", cap20[4], 0);
    check("b2b_l5", cap20[5], 4);
    check("b2b_l6", cap20[6], 4);
    check("b2b_l7", cap20[7], 6);
    check("b2b_l199", cap20[199], 6);
    check("b2b_l200", cap20[200], 8);
    check("b2b_l255", cap20[255], 8);

    // clear-during-sweep: frame A then frame B
    clear_caps(); fill(0, 16); run_frame(0, 0); wait_idle("fa");
    clear_caps(); fill(3, 4); run_frame(1, 0); wait_idle("fb");
    check("fb_l0", cap20[0], 0);
    check("fb_l3", cap20[3], 4);
    check("fb_l255", cap20[255], 4);

    // frame starting 100 cycles into a sweep is dropped
    clear_caps(); fill_random(60); run_frame(2, 0);
    tick(104);
    fill(77, 50); run_frame(0, 0);
    wait_idle("busy_a");
    tick(300);
    check("busy_drop_nvalid", nvalid, 256);
    clear_caps(); fill(9, 5); run_frame(0, 0); wait_idle("after_drop");
    check("after_drop_l255", cap20[255], 5);
    check("after_drop_l77", cap20[77], 5);

    // 4-bit counter overflow
    clear_caps(); fill(0, 20); run_frame(0, 0); wait_idle("ovf");
    check("ovf_l255_w20", cap20[255], 20);
`ifdef HIST_CDF_SAT_EN
    check("ovf_l255_w4", cap4[255], 15);
`else
    check("ovf_l255_w4", cap4[255], 4);
`endif

    // random frames
    for (int f = 0; f < 6; f++) begin
      clear_caps(); fill_random($urandom_range(0, 300));
      run_frame((f % 2 == 0) ? 0 : 3, 0);
      wait_idle("rnd");
      check("rnd_nvalid", nvalid, 256);
      check("rnd_total", cap20[255], pix_q.size());
    end

    // reset in the middle of a sweep, then an empty frame must sweep all zero
    fill_random(200); run_frame(0, 0);
    begin
      int n = 0;
      while (!(m_st == M_SWEEP && m_k >= 60) && n < 400) begin tick(1); n++; end
      check("midrst_reach", (n < 400), 1);
    end
    rst_n = 1'b0; #1;
    check("midrst_valid", bus20.pixel_level_valid, 0);
    check("midrst_level", bus20.pixel_level, 0);
    check("midrst_acc", bus20.pixel_level_acc_num, 0);
    check("midrst_busy", bus20.hist_busy, 1);
    tick(2);
    rst_n = 1'b1;
    wait_init("midrst_init_cycles");
    clear_caps(); pix_q.delete(); run_frame(0, 0); wait_idle("midrst_empty");
    check("midrst_empty_l100", cap20[100], 0);
    check("midrst_empty_l255", cap20[255], 0);

    $display("info: final debug states %0d %0d", dbg20, dbg4);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
